// File: rtl/custom_switches.sv
// custom_switches: Avalon-MM slave that synchronizes and debounces board
// switches/buttons, latches debounced edges and raises a maskable level IRQ.
module custom_switches #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned CNT_W      = 20,
    parameter int unsigned DEFAULT_DB = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] switches_in
);

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_EDGE     = 2'd1;
    localparam logic [1:0] ADDR_MASK     = 2'd2;
    localparam logic [1:0] ADDR_DEBOUNCE = 2'd3;

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_edge;
    logic [WIDTH-1:0] r_mask;
    logic [CNT_W-1:0] r_thr;
    logic [CNT_W-1:0] r_cnt [WIDTH];

    logic [CNT_W-1:0] w_thr_m1;
    logic [WIDTH-1:0] w_done;
    logic [WIDTH-1:0] w_w1c;
    logic [31:0]      w_rd_mux;
    logic             w_unused;

    // Upper write-data bits beyond WIDTH/CNT_W are intentionally ignored.
    assign w_unused = ^avs_writedata;

    // Terminal count; a threshold of 0 is treated like 1.
    always_comb begin
        w_thr_m1 = '0;
        if (r_thr != '0) begin
            w_thr_m1 = r_thr - CNT_W'(1);
        end
    end

    // Per-bit: synchronized input has disagreed with DATA long enough to commit.
    always_comb begin
        w_done = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_done[i] = (r_s2[i] != r_data[i]) && (r_cnt[i] >= w_thr_m1);
        end
    end

    // Write-1-to-clear mask for EDGE.
    always_comb begin
        w_w1c = '0;
        if (avs_write && (avs_address == ADDR_EDGE)) begin
            w_w1c = avs_writedata[WIDTH-1:0];
        end
    end

    // Register read mux, zero-extended to the bus width.
    always_comb begin
        w_rd_mux = '0;
        case (avs_address)
            ADDR_DATA:     w_rd_mux = 32'(r_data);
            ADDR_EDGE:     w_rd_mux = 32'(r_edge);
            ADDR_MASK:     w_rd_mux = 32'(r_mask);
            ADDR_DEBOUNCE: w_rd_mux = 32'(r_thr);
            default:       w_rd_mux = '0;
        endcase
    end

    // Two-flop synchronizer for the asynchronous pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= switches_in;
            r_s2 <= r_s1;
        end
    end

    // Per-bit debounce counters and debounced state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_data <= r_data ^ w_done;
            for (int i = 0; i < int'(WIDTH); i++) begin
                if ((r_s2[i] == r_data[i]) || w_done[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Edge capture; a new edge wins over a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_edge <= '0;
        end else begin
            r_edge <= (r_edge & ~w_w1c) | w_done;
        end
    end

    // MASK and DEBOUNCE control registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask <= '0;
            r_thr  <= CNT_W'(DEFAULT_DB);
        end else if (avs_write) begin
            if (avs_address == ADDR_MASK) begin
                r_mask <= avs_writedata[WIDTH-1:0];
            end
            if (avs_address == ADDR_DEBOUNCE) begin
                r_thr <= avs_writedata[CNT_W-1:0];
            end
        end
    end

    // Registered level interrupt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= |(r_edge & r_mask);
        end
    end

    // Fixed one-cycle read latency; data holds until the next read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= w_rd_mux;
        end
    end

endmodule

// File: tb/tb_custom_switches.sv
// Testbench for custom_switches: directed scenarios plus randomized traffic
// against a window-based behavioural model of the debounce rules.
module tb_custom_switches;

    localparam int HIST = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        irq;
    logic [7:0]  sw;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [7:0]             m_data, m_edge, m_mask;
    logic [19:0]            m_thr;
    logic                   m_irq;
    logic [31:0]            m_rd;
    logic [HIST-1:0][7:0]   m_hist;

    custom_switches #(.WIDTH(8), .CNT_W(20), .DEFAULT_DB(50000)) dut (
        .clk           (clk),
        .reset         (reset),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .irq           (irq),
        .switches_in   (sw)
    );

    always #5 clk = ~clk;

    // A bit flips when the last thr synchronized samples all differ from it.
    // h[j] is the pin value sampled j+1 edges ago; the synchronizer adds 2 edges.
    function automatic logic [7:0] calc_flip(input logic [HIST-1:0][7:0] h,
                                             input logic [7:0] d, input logic [19:0] thr);
        int   eff;
        logic diff;
        calc_flip = '0;
        eff = (thr == 20'd0) ? 1 : int'(thr);
        for (int b = 0; b < 8; b++) begin
            if (eff < HIST) begin
                diff = 1'b1;
                for (int j = 1; j <= eff; j++) begin
                    if (h[j][b] == d[b]) diff = 1'b0;
                end
                calc_flip[b] = diff;
            end
        end
    endfunction

    function automatic logic [31:0] model_mux(input logic [1:0] a);
        case (a)
            2'd0:    model_mux = {24'd0, m_data};
            2'd1:    model_mux = {24'd0, m_edge};
            2'd2:    model_mux = {24'd0, m_mask};
            default: model_mux = {12'd0, m_thr};
        endcase
    endfunction

    function automatic logic [7:0] model_w1c();
        model_w1c = (avs_write && avs_address == 2'd1) ? avs_writedata[7:0] : 8'd0;
    endfunction

    // Reference model, advanced on every DUT clock edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_data <= '0; m_edge <= '0; m_mask <= '0; m_thr <= 20'd50000;
            m_irq  <= 1'b0; m_rd <= '0; m_hist <= '0;
        end else begin
            m_data <= m_data ^ calc_flip(m_hist, m_data, m_thr);
            m_edge <= (m_edge & ~model_w1c()) | calc_flip(m_hist, m_data, m_thr);
            m_irq  <= |(m_edge & m_mask);
            if (avs_read) m_rd <= model_mux(avs_address);
            if (avs_write && avs_address == 2'd2) m_mask <= avs_writedata[7:0];
            if (avs_write && avs_address == 2'd3) m_thr <= avs_writedata[19:0];
            m_hist <= {m_hist[HIST-2:0], sw};
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        avs_write = 1'b1; avs_address = a; avs_writedata = d;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] v);
        avs_read = 1'b1; avs_address = a;
        @(negedge clk);
        avs_read = 1'b0;
        v = avs_readdata;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        bus_write(2'd3, 32'd4);
        bus_write(2'd2, 32'hFF);
        sw = 8'h03;
        cyc(8);
        bus_read(2'd3, v);
        checks++; if (v !== 32'd4) begin errors++; $display("FAIL pre_reset_thr got %0d want 4", v); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got %b want 1", irq); end
        sw = 8'h0C;
        cyc(2);
        #2 reset = 1'b1;
        #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
        checks++; if (avs_readdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", avs_readdata); end
        sw = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        bus_read(2'd0, v);
        checks++; if (v !== 32'd0 || v !== m_rd) begin errors++; $display("FAIL reset_data got %h want 0", v); end
        bus_read(2'd1, v);
        checks++; if (v !== 32'd0 || v !== m_rd) begin errors++; $display("FAIL reset_edge got %h want 0", v); end
        bus_read(2'd2, v);
        checks++; if (v !== 32'd0 || v !== m_rd) begin errors++; $display("FAIL reset_mask got %h want 0", v); end
        bus_read(2'd3, v);
        checks++; if (v !== 32'd50000 || v !== m_rd) begin errors++; $display("FAIL reset_thr got %0d want 50000", v); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq_after got %b want 0", irq); end
    endtask

    task automatic test_debounce_latency();
        logic [31:0] v;
        int first;
        first = 0;
        bus_write(2'd3, 32'd4);
        sw = 8'h01;
        avs_read = 1'b1; avs_address = 2'd0;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            checks++; if (avs_readdata !== m_rd) begin errors++; $display("FAIL latency_model n=%0d got %h want %h", n, avs_readdata, m_rd); end
            if (avs_readdata[0] === 1'b1 && first == 0) first = n;
        end
        avs_read = 1'b0;
        // DATA updates on edge k+5; a read sampled on edge k+6 is the first to see it.
        checks++; if (first != 7) begin errors++; $display("FAIL latency_cycles got %0d want 7", first); end
        bus_read(2'd1, v);
        checks++; if (v !== 32'h01) begin errors++; $display("FAIL latency_edge got %h want 01", v); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL latency_irq got %b want 0", irq); end
    endtask

    task automatic test_glitch();
        logic [31:0] v;
        logic saw;
        saw = 1'b0;
        sw = 8'h09; cyc(3); sw = 8'h01; cyc(10);
        bus_read(2'd0, v);
        checks++; if (v !== 32'h01 || v !== m_rd) begin errors++; $display("FAIL glitch3_data got %h want 01", v); end
        bus_read(2'd1, v);
        checks++; if (v !== 32'h01 || v !== m_rd) begin errors++; $display("FAIL glitch3_edge got %h want 01", v); end
        sw = 8'h09; cyc(4); sw = 8'h01;
        avs_read = 1'b1; avs_address = 2'd0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            checks++; if (avs_readdata !== m_rd) begin errors++; $display("FAIL glitch4_model n=%0d got %h want %h", n, avs_readdata, m_rd); end
            if (avs_readdata === 32'h09) saw = 1'b1;
        end
        avs_read = 1'b0;
        checks++; if (saw !== 1'b1) begin errors++; $display("FAIL glitch4_toggle got %b want 1", saw); end
        checks++; if (avs_readdata !== 32'h01) begin errors++; $display("FAIL glitch4_back got %h want 01", avs_readdata); end
        bus_read(2'd1, v);
        checks++; if (v !== 32'h09) begin errors++; $display("FAIL glitch4_edge got %h want 09", v); end
    endtask

    task automatic test_irq();
        int ne, ni;
        ne = -1; ni = -1;
        bus_write(2'd1, 32'hFF);
        bus_write(2'd2, 32'h01);
        cyc(1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle got %b want 0", irq); end
        sw = 8'h00;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            checks++; if (irq !== m_irq) begin errors++; $display("FAIL irq_model n=%0d got %b want %b", n, irq, m_irq); end
            if (m_edge[0] && ne < 0) ne = n;
            if (irq === 1'b1 && ni < 0) ni = n;
        end
        checks++; if (ne < 0 || ni != ne + 1) begin errors++; $display("FAIL irq_delay got %0d want %0d", ni, ne + 1); end
        bus_write(2'd1, 32'h01);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold got %b want 1", irq); end
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", irq); end
    endtask

    task automatic test_w1c_collision();
        logic [31:0] v;
        bus_write(2'd1, 32'hFF);
        bus_write(2'd2, 32'h04);
        sw = 8'h04;
        cyc(5);
        avs_write = 1'b1; avs_address = 2'd1; avs_writedata = 32'h04;
        @(negedge clk);
        avs_write = 1'b0;
        bus_read(2'd1, v);
        checks++; if (v !== 32'h04 || v !== m_rd) begin errors++; $display("FAIL collide_edge got %h want 04", v); end
        cyc(1);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL collide_irq got %b want 1", irq); end
    endtask

    task automatic test_thr_zero();
        logic [31:0] v;
        bus_write(2'd3, 32'd0);
        bus_read(2'd3, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL thr0_read got %0d want 0", v); end
        bus_write(2'd1, 32'hFF);
        sw = 8'h06; @(negedge clk); sw = 8'h04; cyc(4);
        bus_read(2'd1, v);
        checks++; if (v !== 32'h02 || v !== m_rd) begin errors++; $display("FAIL thr0_edge got %h want 02", v); end
        bus_read(2'd0, v);
        checks++; if (v !== 32'h04) begin errors++; $display("FAIL thr0_data got %h want 04", v); end
        bus_write(2'd0, 32'hFF);
        bus_read(2'd0, v);
        checks++; if (v !== 32'h04) begin errors++; $display("FAIL data_ro got %h want 04", v); end
        avs_read = 1'b1; avs_write = 1'b1; avs_address = 2'd2; avs_writedata = 32'hFFFF_FFA5;
        @(negedge clk);
        avs_read = 1'b0; avs_write = 1'b0;
        checks++; if (avs_readdata !== 32'h04) begin errors++; $display("FAIL rw_same_old got %h want 04", avs_readdata); end
        bus_read(2'd2, v);
        checks++; if (v !== 32'hA5) begin errors++; $display("FAIL rw_same_new got %h want a5", v); end
        avs_read = 1'b1; avs_write = 1'b1; avs_address = 2'd3; avs_writedata = 32'd7;
        @(negedge clk);
        avs_read = 1'b0; avs_write = 1'b0;
        checks++; if (avs_readdata !== 32'd0) begin errors++; $display("FAIL rw_thr_old got %0d want 0", avs_readdata); end
        bus_read(2'd3, v);
        checks++; if (v !== 32'd7) begin errors++; $display("FAIL rw_thr_new got %0d want 7", v); end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [1:0]  a;
        int          op;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) sw = sw ^ 8'($urandom_range(0, 255) & $urandom_range(0, 255));
            op = int'($urandom_range(0, 9));
            a  = 2'($urandom_range(0, 3));
            d  = (a == 2'd3) ? 32'($urandom_range(0, 6)) : $urandom;
            avs_address = a; avs_writedata = d;
            avs_read  = (op < 5);
            avs_write = (op == 5 || op == 6);
            @(negedge clk);
            checks++; if (avs_readdata !== m_rd) begin errors++; $display("FAIL rand_rdata n=%0d got %h want %h", n, avs_readdata, m_rd); end
            checks++; if (irq !== m_irq) begin errors++; $display("FAIL rand_irq n=%0d got %b want %b", n, irq, m_irq); end
        end
        avs_read = 1'b0; avs_write = 1'b0;
    endtask

    initial begin
        reset = 1'b1; sw = 8'h00;
        avs_address = 2'd0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = 32'd0;
        cyc(2);
        reset = 1'b0;
        cyc(1);
        test_reset();
        test_debounce_latency();
        test_glitch();
        test_irq();
        test_w1c_collision();
        test_thr_zero();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
